updown_counter: RTL and testbench



---
 rtl/updown_counter_pkg.sv | 6 +
 rtl/updown_counter_next.sv | 17 +
 rtl/updown_counter.sv | 26 ++
 tb/tb_updown_counter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: shared direction and reset-value constants for the up/down counter
package updown_counter_pkg;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  localparam logic [63:0] COUNT_RST = '0;
endpackage

// File: rtl/updown_counter_next.sv
// updown_counter_next: combinational next count (i_count, i_tm_reset, i_tm_direction -> o_next), clear beats direction, modulo 2^COUNT_WD
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int COUNT_WD = 16
) (
  input  logic [COUNT_WD-1:0] i_count,
  input  logic                i_tm_reset,
  input  logic                i_tm_direction,
  output logic [COUNT_WD-1:0] o_next
);
  localparam logic [COUNT_WD-1:0] ONE = COUNT_WD'(1);
  always_comb begin
    o_next = i_tm_reset ? COUNT_RST[COUNT_WD-1:0] :
             (i_tm_direction == DIR_UP) ? i_count + ONE : i_count - ONE;
  end
endmodule

// File: rtl/updown_counter.sv
// updown_counter: free-running up/down counter; i_clk, async active-high i_rstb, i_tm_reset clear, i_tm_direction (1=up), registered o_count
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int COUNT_WD = 16
) (
  input  logic                i_clk,
  input  logic                i_rstb,
  input  logic                i_tm_reset,
  input  logic                i_tm_direction,
  output logic [COUNT_WD-1:0] o_count
);
  logic [COUNT_WD-1:0] count_q;
  logic [COUNT_WD-1:0] count_d;
  updown_counter_next #(.COUNT_WD(COUNT_WD)) u_next (
    .i_count        (count_q),
    .i_tm_reset     (i_tm_reset),
    .i_tm_direction (i_tm_direction),
    .o_next         (count_d)
  );
  always_ff @(posedge i_clk or posedge i_rstb) begin
    if (i_rstb) count_q <= COUNT_RST[COUNT_WD-1:0];
    else count_q <= count_d;
  end
  assign o_count = count_q;
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: randomized and directed checks of 16-bit and 4-bit counters against an arithmetic model
module tb_updown_counter;
  logic clk;
  logic rstb;
  logic tm_reset;
  logic tm_dir;
  logic [15:0] cnt16;
  logic [3:0] cnt4;
  int compared;
  int mismatched;
  int exp16;
  int exp4;
  updown_counter #(.COUNT_WD(16)) dut16 (
    .i_clk          (clk),
    .i_rstb         (rstb),
    .i_tm_reset     (tm_reset),
    .i_tm_direction (tm_dir),
    .o_count        (cnt16)
  );
  updown_counter #(.COUNT_WD(4)) dut4 (
    .i_clk          (clk),
    .i_rstb         (rstb),
    .i_tm_reset     (tm_reset),
    .i_tm_direction (tm_dir),
    .o_count        (cnt4)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model16", {48'b0, cnt16}, 64'(exp16));
    chk("model4", {60'b0, cnt4}, 64'(exp4));
  end
  task automatic step(input logic r, input logic d);
    tm_reset = r;
    tm_dir = d;
    @(posedge clk);
    if (!rstb) begin
      exp16 = r ? 0 : (exp16 + (d ? 1 : 65535)) % 65536;
      exp4 = r ? 0 : (exp4 + (d ? 1 : 15)) % 16;
    end
    #1;
  endtask
  task automatic async_reset_pulse(input int held_edges);
    #1;
    rstb = 1'b1;
    exp16 = 0;
    exp4 = 0;
    #1;
    chk("async_rst16", {48'b0, cnt16}, 64'h0);
    chk("async_rst4", {60'b0, cnt4}, 64'h0);
    for (int i = 0; i < held_edges; i++) begin
      step(1'b0, 1'($urandom_range(1)));
      chk("rst_held", {48'b0, cnt16}, 64'h0);
    end
    rstb = 1'b0;
  endtask
  initial begin
    compared = 0;
    mismatched = 0;
    exp16 = 0;
    exp4 = 0;
    rstb = 1'b1;
    tm_reset = 1'b0;
    tm_dir = 1'b1;
    #2;
    chk("reset16", {48'b0, cnt16}, 64'h0);
    chk("reset4", {60'b0, cnt4}, 64'h0);
    @(posedge clk);
    #1;
    chk("reset_hold", {48'b0, cnt16}, 64'h0);
    rstb = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("up10", {48'b0, cnt16}, 64'h000A);
    chk("up10_w4", {60'b0, cnt4}, 64'hA);
    step(1'b1, 1'b1);
    chk("clr", {48'b0, cnt16}, 64'h0);
    step(1'b0, 1'b0);
    chk("down_wrap", {48'b0, cnt16}, 64'hFFFF);
    chk("down_wrap_w4", {60'b0, cnt4}, 64'hF);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("down3", {48'b0, cnt16}, 64'hFFFD);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("preload", {48'b0, cnt16}, 64'hFFFE);
    step(1'b0, 1'b1);
    chk("up_ffff", {48'b0, cnt16}, 64'hFFFF);
    chk("up_f_w4", {60'b0, cnt4}, 64'hF);
    step(1'b0, 1'b1);
    chk("up_wrap", {48'b0, cnt16}, 64'h0000);
    chk("up_wrap_w4", {60'b0, cnt4}, 64'h0);
    for (int i = 0; i < 16'h1234; i++) step(1'b0, 1'b1);
    chk("at1234", {48'b0, cnt16}, 64'h1234);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'(i % 2));
      chk("clr_prio", {48'b0, cnt16}, 64'h0);
    end
    step(1'b0, 1'b0);
    chk("clr_release_down", {48'b0, cnt16}, 64'hFFFF);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("to5", {48'b0, cnt16}, 64'h5);
    step(1'b0, 1'b1);
    chk("tog6", {48'b0, cnt16}, 64'h6);
    step(1'b0, 1'b0);
    chk("tog5", {48'b0, cnt16}, 64'h5);
    step(1'b0, 1'b0);
    chk("tog4", {48'b0, cnt16}, 64'h4);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("to7", {48'b0, cnt16}, 64'h7);
    async_reset_pulse(2);
    step(1'b0, 1'b1);
    chk("post_rst_up", {48'b0, cnt16}, 64'h1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) async_reset_pulse(int'($urandom_range(2)));
      else step(1'($urandom_range(7) == 0), 1'($urandom_range(3) != 0));
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
